// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router ingress control path.
package router_pkg;

    localparam int unsigned RTR_ADDR_W   = 2;
    localparam int unsigned RTR_NUM_DEST = 3;

    // Header address value that names no destination FIFO
    localparam logic [RTR_ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    // One-hot destination select; the invalid address selects nothing
    function automatic logic [RTR_NUM_DEST-1:0] addr_onehot(input logic [RTR_ADDR_W-1:0] a);
        logic [RTR_NUM_DEST-1:0] sel;
        case (a)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Ingress control FSM: decodes the header address, waits for the target FIFO
// to drain, then sequences header, payload, full-stall and parity handling.
module router_fsm
    import router_pkg::*;
#(
    parameter int unsigned ADDR_W   = RTR_ADDR_W,
    parameter int unsigned NUM_DEST = RTR_NUM_DEST
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                pkt_valid,
    input  logic [ADDR_W-1:0]   data_in,
    input  logic                fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] soft_reset,
    input  logic                parity_done,
    input  logic                low_pkt_valid,
    output logic                detect_add,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                laf_state,
    output logic                full_state,
    output logic                rst_int_reg,
    output logic                write_enb_reg,
    output logic                busy,
    output logic [NUM_DEST-1:0] dest_sel
);

    state_t                r_state;
    logic [ADDR_W-1:0]     r_addr;

    logic                  r_detect_add;
    logic                  r_lfd_state;
    logic                  r_ld_state;
    logic                  r_laf_state;
    logic                  r_full_state;
    logic                  r_rst_int_reg;
    logic                  r_write_enb_reg;
    logic                  r_busy;
    logic [NUM_DEST-1:0]   r_dest_sel;

    state_t                w_next_state;
    logic [ADDR_W-1:0]     w_next_addr;
    logic [NUM_DEST-1:0]   w_sel_in;
    logic [NUM_DEST-1:0]   w_sel_q;
    logic                  w_in_valid;
    logic                  w_soft;

    // Next-state and next-address selection; a soft reset on the latched port wins over everything
    always_comb begin
        w_sel_in     = addr_onehot(data_in);
        w_sel_q      = addr_onehot(r_addr);
        w_in_valid   = (data_in != ADDR_INVALID);
        w_soft       = |(soft_reset & w_sel_q);
        w_next_state = r_state;
        w_next_addr  = r_addr;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid && w_in_valid) begin
                    w_next_addr  = data_in;
                    w_next_state = (|(fifo_empty & w_sel_in)) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       w_next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) w_next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)      w_next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        w_next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) w_next_state = LOAD_PARITY;
                else                    w_next_state = LOAD_DATA;
            end
            LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (|(fifo_empty & w_sel_q)) w_next_state = LOAD_FIRST_DATA;
            end
            default: w_next_state = DECODE_ADDRESS;
        endcase
        if (w_soft) begin
            w_next_state = DECODE_ADDRESS;
            w_next_addr  = ADDR_INVALID;
        end
    end

    // State/address registers; outputs are decoded from the next state so they align with the state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state         <= DECODE_ADDRESS;
            r_addr          <= ADDR_INVALID;
            r_detect_add    <= 1'b1;
            r_lfd_state     <= 1'b0;
            r_ld_state      <= 1'b0;
            r_laf_state     <= 1'b0;
            r_full_state    <= 1'b0;
            r_rst_int_reg   <= 1'b0;
            r_write_enb_reg <= 1'b0;
            r_busy          <= 1'b0;
            r_dest_sel      <= '0;
        end else begin
            r_state         <= w_next_state;
            r_addr          <= w_next_addr;
            r_detect_add    <= (w_next_state == DECODE_ADDRESS);
            r_lfd_state     <= (w_next_state == LOAD_FIRST_DATA);
            r_ld_state      <= (w_next_state == LOAD_DATA);
            r_laf_state     <= (w_next_state == LOAD_AFTER_FULL);
            r_full_state    <= (w_next_state == FIFO_FULL_STATE);
            r_rst_int_reg   <= (w_next_state == CHECK_PARITY_ERROR);
            r_write_enb_reg <= (w_next_state == LOAD_DATA) ||
                               (w_next_state == LOAD_PARITY) ||
                               (w_next_state == LOAD_AFTER_FULL);
            r_busy          <= !((w_next_state == DECODE_ADDRESS) || (w_next_state == LOAD_DATA));
            r_dest_sel      <= addr_onehot(w_next_addr);
        end
    end

    assign detect_add    = r_detect_add;
    assign lfd_state     = r_lfd_state;
    assign ld_state      = r_ld_state;
    assign laf_state     = r_laf_state;
    assign full_state    = r_full_state;
    assign rst_int_reg   = r_rst_int_reg;
    assign write_enb_reg = r_write_enb_reg;
    assign busy          = r_busy;
    assign dest_sel      = r_dest_sel;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm with hand-derived per-state output vectors.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [2:0] dest_sel;
    logic [7:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    localparam int S_DA  = 0;
    localparam int S_LFD = 1;
    localparam int S_LD  = 2;
    localparam int S_FFS = 3;
    localparam int S_LAF = 4;
    localparam int S_LP  = 5;
    localparam int S_CPE = 6;
    localparam int S_WTE = 7;

    router_fsm #(.ADDR_W(2), .NUM_DEST(3)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy),
        .dest_sel      (dest_sel)
    );

    always #5 clock = ~clock;

    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy};

    // Output vector {detect,lfd,ld,laf,full,rst_int,wen,busy} expected in each state
    function automatic logic [7:0] exp_outs(input int s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0010;
            S_LAF:   return 8'b0001_0011;
            S_FFS:   return 8'b0000_1001;
            S_LP:    return 8'b0000_0011;
            S_CPE:   return 8'b0000_0101;
            default: return 8'b0000_0001;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_st(input string tag, input int s, input logic [2:0] ds);
        check_eq({tag, "_outs"}, {24'd0, outs}, {24'd0, exp_outs(s)});
        check_eq({tag, "_dsel"}, {29'd0, dest_sel}, {29'd0, ds});
    endtask

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 2'b00;
        fifo_full     = 1'b0;
        fifo_empty    = 3'b111;
        soft_reset    = 3'b000;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        tick();
        tick();
        expect_st("reset", S_DA, 3'b000);
        resetn = 1'b1;
        tick();
        expect_st("idle", S_DA, 3'b000);

        // Invalid header address is ignored
        pkt_valid = 1'b1; data_in = 2'b11;
        tick();
        expect_st("bad_addr", S_DA, 3'b000);
        tick();
        expect_st("bad_addr2", S_DA, 3'b000);

        // Packet to port 1, empty FIFO, three payload bytes
        data_in = 2'b01;
        tick(); expect_st("p1_lfd", S_LFD, 3'b010);
        data_in = 2'b11;
        tick(); expect_st("p1_ld1", S_LD, 3'b010);
        tick(); expect_st("p1_ld2", S_LD, 3'b010);
        tick(); expect_st("p1_ld3", S_LD, 3'b010);
        pkt_valid = 1'b0;
        tick(); expect_st("p1_lp", S_LP, 3'b010);
        tick(); expect_st("p1_cpe", S_CPE, 3'b010);
        tick(); expect_st("p1_da", S_DA, 3'b010);

        // Port 2 busy FIFO: wait four cycles
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'b10;
        tick(); expect_st("p2_wte1", S_WTE, 3'b100);
        data_in = 2'b00;
        tick(); expect_st("p2_wte2", S_WTE, 3'b100);
        tick(); expect_st("p2_wte3", S_WTE, 3'b100);
        tick(); expect_st("p2_wte4", S_WTE, 3'b100);
        fifo_empty = 3'b111;
        tick(); expect_st("p2_lfd", S_LFD, 3'b100);
        tick(); expect_st("p2_ld", S_LD, 3'b100);

        // Full stall, resume into LOAD_DATA
        fifo_full = 1'b1;
        tick(); expect_st("p2_ffs1", S_FFS, 3'b100);
        tick(); expect_st("p2_ffs2", S_FFS, 3'b100);
        fifo_full = 1'b0;
        tick(); expect_st("p2_laf1", S_LAF, 3'b100);
        tick(); expect_st("p2_laf_ld", S_LD, 3'b100);

        // Full stall, pkt_valid dropped during stall -> parity
        fifo_full = 1'b1;
        tick(); expect_st("p2_ffs3", S_FFS, 3'b100);
        tick(); expect_st("p2_ffs4", S_FFS, 3'b100);
        fifo_full = 1'b0;
        tick(); expect_st("p2_laf2", S_LAF, 3'b100);
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        tick(); expect_st("p2_laf_lp", S_LP, 3'b100);
        low_pkt_valid = 1'b0;
        tick(); expect_st("p2_cpe", S_CPE, 3'b100);

        // FIFO full at parity check, then parity_done ends the packet from LAF
        fifo_full = 1'b1;
        tick(); expect_st("p2_cpe_ffs", S_FFS, 3'b100);
        fifo_full = 1'b0;
        tick(); expect_st("p2_laf3", S_LAF, 3'b100);
        parity_done = 1'b1;
        tick(); expect_st("p2_laf_da", S_DA, 3'b100);
        parity_done = 1'b0;

        // Soft reset: non-selected port ignored, selected port aborts
        pkt_valid = 1'b1; data_in = 2'b00;
        tick(); expect_st("p0_lfd", S_LFD, 3'b001);
        tick(); expect_st("p0_ld", S_LD, 3'b001);
        soft_reset = 3'b100;
        tick(); expect_st("p0_sr2_ign", S_LD, 3'b001);
        soft_reset = 3'b001;
        tick(); expect_st("p0_sr0", S_DA, 3'b000);
        soft_reset = 3'b000; pkt_valid = 1'b0;
        tick(); expect_st("p0_idle", S_DA, 3'b000);

        // Async reset mid-LOAD_DATA
        pkt_valid = 1'b1; data_in = 2'b01;
        tick(); expect_st("r_lfd", S_LFD, 3'b010);
        tick(); expect_st("r_ld", S_LD, 3'b010);
        resetn = 1'b0;
        #1;
        expect_st("async_rst", S_DA, 3'b000);
        pkt_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick(); expect_st("post_rst", S_DA, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
